// File: rtl/multicycle_control.sv
// Control FSM for a multicycle RISC-V-style datapath: sequences fetch, decode,
// execute, memory and write-back, and counts retired instructions.
module multicycle_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic [1:0]  alu_op,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        ir_write,
    output logic        pc_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        pc_src,
    output logic        mem_to_reg,
    output logic        illegal,
    output logic [3:0]  state,
    output logic [31:0] instr_count
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WR   = 4'd6,
        WB_ALU   = 4'd7,
        WB_MEM   = 4'd8,
        BRANCH   = 4'd9,
        TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t      state_r;
    state_t      state_next_s;
    logic        illegal_r;
    logic [31:0] instr_count_r;
    logic        retire_s;

    logic [1:0]  alu_op_s;
    logic [1:0]  alu_src_a_s;
    logic [1:0]  alu_src_b_s;
    logic        ir_write_s;
    logic        pc_write_s;
    logic        mem_read_s;
    logic        mem_write_s;
    logic        reg_write_s;
    logic        pc_src_s;
    logic        mem_to_reg_s;

    // State, sticky illegal flag and retirement counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= FETCH;
            illegal_r     <= 1'b0;
            instr_count_r <= 32'd0;
        end else begin
            state_r <= state_next_s;
            if (state_next_s == TRAP) begin
                illegal_r <= 1'b1;
            end else begin
                illegal_r <= illegal_r;
            end
            if (retire_s) begin
                instr_count_r <= instr_count_r + 32'd1;
            end else begin
                instr_count_r <= instr_count_r;
            end
        end
    end

    // Next-state and raw per-state output decode.
    always_comb begin
        state_next_s = state_r;
        retire_s     = 1'b0;
        alu_op_s     = 2'b00;
        alu_src_a_s  = 2'b00;
        alu_src_b_s  = 2'b00;
        ir_write_s   = 1'b0;
        pc_write_s   = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        reg_write_s  = 1'b0;
        pc_src_s     = 1'b0;
        mem_to_reg_s = 1'b0;
        case (state_r)
            FETCH: begin
                mem_read_s  = 1'b1;
                alu_src_b_s = 2'b01;
                if (mem_ready) begin
                    ir_write_s   = 1'b1;
                    pc_write_s   = 1'b1;
                    state_next_s = DECODE;
                end else begin
                    state_next_s = FETCH;
                end
            end
            DECODE: begin
                // ALU forms the branch target (old PC + imm) speculatively here.
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b10;
                case (opcode)
                    OP_R:               state_next_s = EXEC_R;
                    OP_I:               state_next_s = EXEC_I;
                    OP_LOAD, OP_STORE:  state_next_s = MEM_ADDR;
                    OP_BRANCH:          state_next_s = BRANCH;
                    default:            state_next_s = TRAP;
                endcase
            end
            EXEC_R: begin
                alu_src_a_s  = 2'b01;
                alu_op_s     = 2'b10;
                state_next_s = WB_ALU;
            end
            EXEC_I: begin
                alu_src_a_s  = 2'b01;
                alu_src_b_s  = 2'b10;
                alu_op_s     = 2'b11;
                state_next_s = WB_ALU;
            end
            MEM_ADDR: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b10;
                if (opcode == OP_LOAD) begin
                    state_next_s = MEM_RD;
                end else begin
                    state_next_s = MEM_WR;
                end
            end
            MEM_RD: begin
                mem_read_s = 1'b1;
                if (mem_ready) begin
                    state_next_s = WB_MEM;
                end else begin
                    state_next_s = MEM_RD;
                end
            end
            MEM_WR: begin
                mem_write_s = 1'b1;
                if (mem_ready) begin
                    state_next_s = FETCH;
                    retire_s     = 1'b1;
                end else begin
                    state_next_s = MEM_WR;
                end
            end
            WB_ALU: begin
                reg_write_s  = 1'b1;
                state_next_s = FETCH;
                retire_s     = 1'b1;
            end
            WB_MEM: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 1'b1;
                state_next_s = FETCH;
                retire_s     = 1'b1;
            end
            BRANCH: begin
                alu_src_a_s  = 2'b01;
                alu_op_s     = 2'b01;
                pc_src_s     = 1'b1;
                pc_write_s   = branch_taken;
                state_next_s = FETCH;
                retire_s     = 1'b1;
            end
            TRAP: begin
                state_next_s = TRAP;
            end
            default: begin
                // Unused encodings are treated as a fault.
                state_next_s = TRAP;
            end
        endcase
    end

    // Reset masks every enable immediately so an abandoned access writes nothing.
    always_comb begin
        if (rst) begin
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end else begin
            ir_write  = ir_write_s;
            pc_write  = pc_write_s;
            mem_read  = mem_read_s;
            mem_write = mem_write_s;
            reg_write = reg_write_s;
        end
    end

    assign alu_op      = alu_op_s;
    assign alu_src_a   = alu_src_a_s;
    assign alu_src_b   = alu_src_b_s;
    assign pc_src      = pc_src_s;
    assign mem_to_reg  = mem_to_reg_s;
    assign illegal     = illegal_r;
    assign state       = state_r;
    assign instr_count = instr_count_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: directed per-cycle vectors push
// expected outputs; a negedge monitor pops and compares them.
module tb_multicycle_control;

    logic        clk;
    logic        rst;
    logic [6:0]  opcode;
    logic        mem_ready;
    logic        branch_taken;
    logic [1:0]  alu_op;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic        ir_write;
    logic        pc_write;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        pc_src;
    logic        mem_to_reg;
    logic        illegal;
    logic [3:0]  state;
    logic [31:0] instr_count;

    localparam logic [3:0] S_F  = 4'd0;
    localparam logic [3:0] S_D  = 4'd1;
    localparam logic [3:0] S_ER = 4'd2;
    localparam logic [3:0] S_EI = 4'd3;
    localparam logic [3:0] S_MA = 4'd4;
    localparam logic [3:0] S_MR = 4'd5;
    localparam logic [3:0] S_MW = 4'd6;
    localparam logic [3:0] S_WA = 4'd7;
    localparam logic [3:0] S_WM = 4'd8;
    localparam logic [3:0] S_BR = 4'd9;
    localparam logic [3:0] S_T  = 4'd15;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_L   = 7'b0000011;
    localparam logic [6:0] OP_S   = 7'b0100011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic [49:0] exp_q[$];
    string       tag_q[$];
    int          checks;
    int          errors;

    multicycle_control dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .mem_ready    (mem_ready),
        .branch_taken (branch_taken),
        .alu_op       (alu_op),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .reg_write    (reg_write),
        .pc_src       (pc_src),
        .mem_to_reg   (mem_to_reg),
        .illegal      (illegal),
        .state        (state),
        .instr_count  (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output word for a hand-specified state and this cycle's inputs.
    function automatic logic [49:0] expv(input logic [3:0] st, input logic mr, input logic bt,
                                         input logic r, input logic ill, input logic [31:0] cnt);
        logic [1:0] op, a, b;
        logic irw, pcw, mrd, mwr, rw, pcs, m2r;
        op = 2'b00; a = 2'b00; b = 2'b00;
        irw = 1'b0; pcw = 1'b0; mrd = 1'b0; mwr = 1'b0; rw = 1'b0; pcs = 1'b0; m2r = 1'b0;
        case (st)
            S_F:  begin mrd = 1'b1; b = 2'b01; irw = mr; pcw = mr; end
            S_D:  begin a = 2'b10; b = 2'b10; end
            S_ER: begin a = 2'b01; op = 2'b10; end
            S_EI: begin a = 2'b01; b = 2'b10; op = 2'b11; end
            S_MA: begin a = 2'b01; b = 2'b10; end
            S_MR: mrd = 1'b1;
            S_MW: mwr = 1'b1;
            S_WA: rw = 1'b1;
            S_WM: begin rw = 1'b1; m2r = 1'b1; end
            S_BR: begin a = 2'b01; op = 2'b01; pcs = 1'b1; pcw = bt; end
            default: ;
        endcase
        if (r) begin
            irw = 1'b0; pcw = 1'b0; mrd = 1'b0; mwr = 1'b0; rw = 1'b0;
        end
        return {st, op, a, b, irw, pcw, mrd, mwr, rw, pcs, m2r, ill, cnt};
    endfunction

    task automatic cyc(input string tag, input logic [3:0] st, input logic [6:0] op,
                       input logic mr, input logic bt, input logic r,
                       input logic ill, input logic [31:0] cnt);
        @(posedge clk);
        #1;
        opcode       = op;
        mem_ready    = mr;
        branch_taken = bt;
        rst          = r;
        exp_q.push_back(expv(st, mr, bt, r, ill, cnt));
        tag_q.push_back(tag);
    endtask

    // Monitor: compare whatever the DUT shows mid-cycle against the queued expectation.
    always @(negedge clk) begin
        logic [49:0] e;
        logic [49:0] act;
        string       t;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            t   = tag_q.pop_front();
            act = {state, alu_op, alu_src_a, alu_src_b, ir_write, pc_write, mem_read,
                   mem_write, reg_write, pc_src, mem_to_reg, illegal, instr_count};
            checks = checks + 1;
            if (act !== e) begin
                errors = errors + 1;
                $display("FAIL %s: got st=%0d op=%b a=%b b=%b en(ir,pc,mr,mw,rw)=%b pcs=%b m2r=%b ill=%b cnt=%h ; expected st=%0d op=%b a=%b b=%b en=%b pcs=%b m2r=%b ill=%b cnt=%h",
                         t, act[49:46], act[45:44], act[43:42], act[41:40], act[39:35], act[34], act[33], act[32], act[31:0],
                         e[49:46], e[45:44], e[43:42], e[41:40], e[39:35], e[34], e[33], e[32], e[31:0]);
            end
        end
    end

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        opcode       = OP_R;
        mem_ready    = 1'b0;
        branch_taken = 1'b0;

        // Reset: FETCH, enables masked.
        cyc("reset0", S_F, OP_R, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        cyc("reset1", S_F, OP_R, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);

        // R-type, no waits: 0,1,2,7,0.
        cyc("r_fetch", S_F,  OP_R,   1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        cyc("r_dec",   S_D,  OP_R,   1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        cyc("r_exec",  S_ER, OP_BAD, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        cyc("r_wb",    S_WA, OP_R,   1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

        // I-type with one fetch wait.
        cyc("i_fwait", S_F,  OP_I, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1);
        cyc("i_fetch", S_F,  OP_I, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1);
        cyc("i_dec",   S_D,  OP_I, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1);
        cyc("i_exec",  S_EI, OP_I, 1'b1, 1'b0, 1'b0, 1'b0, 32'd1);
        cyc("i_wb",    S_WA, OP_I, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1);

        // Load with two MEM_RD wait cycles: 0,1,4,5,5,5,8,0.
        cyc("ld_fetch", S_F,  OP_L,   1'b1, 1'b0, 1'b0, 1'b0, 32'd2);
        cyc("ld_dec",   S_D,  OP_L,   1'b0, 1'b0, 1'b0, 1'b0, 32'd2);
        cyc("ld_addr",  S_MA, OP_L,   1'b1, 1'b0, 1'b0, 1'b0, 32'd2);
        cyc("ld_wait0", S_MR, OP_BAD, 1'b0, 1'b0, 1'b0, 1'b0, 32'd2);
        cyc("ld_wait1", S_MR, OP_S,   1'b0, 1'b0, 1'b0, 1'b0, 32'd2);
        cyc("ld_rd",    S_MR, OP_L,   1'b1, 1'b0, 1'b0, 1'b0, 32'd2);
        cyc("ld_wb",    S_WM, OP_L,   1'b0, 1'b0, 1'b0, 1'b0, 32'd2);

        // Store with one MEM_WR wait.
        cyc("st_fetch", S_F,  OP_S, 1'b1, 1'b0, 1'b0, 1'b0, 32'd3);
        cyc("st_dec",   S_D,  OP_S, 1'b1, 1'b0, 1'b0, 1'b0, 32'd3);
        cyc("st_addr",  S_MA, OP_S, 1'b0, 1'b0, 1'b0, 1'b0, 32'd3);
        cyc("st_wait",  S_MW, OP_S, 1'b0, 1'b0, 1'b0, 1'b0, 32'd3);
        cyc("st_wr",    S_MW, OP_S, 1'b1, 1'b0, 1'b0, 1'b0, 32'd3);

        // Branch not taken, then taken.
        cyc("bn_fetch", S_F,  OP_B, 1'b1, 1'b0, 1'b0, 1'b0, 32'd4);
        cyc("bn_dec",   S_D,  OP_B, 1'b0, 1'b1, 1'b0, 1'b0, 32'd4);
        cyc("bn_br",    S_BR, OP_B, 1'b0, 1'b0, 1'b0, 1'b0, 32'd4);
        cyc("bt_fetch", S_F,  OP_B, 1'b1, 1'b0, 1'b0, 1'b0, 32'd5);
        cyc("bt_dec",   S_D,  OP_B, 1'b0, 1'b0, 1'b0, 1'b0, 32'd5);
        cyc("bt_br",    S_BR, OP_B, 1'b1, 1'b1, 1'b0, 1'b0, 32'd5);

        // Reset during a store memory wait: abandoned, count unchanged.
        cyc("rs_fetch", S_F,  OP_S, 1'b1, 1'b0, 1'b0, 1'b0, 32'd6);
        cyc("rs_dec",   S_D,  OP_S, 1'b0, 1'b0, 1'b0, 1'b0, 32'd6);
        cyc("rs_addr",  S_MA, OP_S, 1'b0, 1'b0, 1'b0, 1'b0, 32'd6);
        cyc("rs_wait",  S_MW, OP_S, 1'b0, 1'b0, 1'b0, 1'b0, 32'd6);
        cyc("rs_rst",   S_MW, OP_S, 1'b0, 1'b0, 1'b1, 1'b0, 32'd6);
        cyc("rs_hold",  S_F,  OP_R, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        cyc("rs_rel",   S_F,  OP_R, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        cyc("rs2_fet",  S_F,  OP_R, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        cyc("rs2_dec",  S_D,  OP_R, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        cyc("rs2_exe",  S_ER, OP_R, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        cyc("rs2_wb",   S_WA, OP_R, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

        // Counter wrap: preload all-ones, retire one store.
        cyc("wr_fetch", S_F, OP_S, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
        force dut.instr_count_r = 32'hFFFF_FFFF;
        #1;
        release dut.instr_count_r;
        cyc("wr_dec",  S_D,  OP_S, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
        cyc("wr_addr", S_MA, OP_S, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
        cyc("wr_wr",   S_MW, OP_S, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);

        // Illegal opcode: TRAP is absorbing and illegal is sticky until reset.
        cyc("tr_fetch", S_F, OP_BAD, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        cyc("tr_dec",   S_D, OP_BAD, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 11; i++) begin
            cyc("tr_hold", S_T, OP_R, 1'b1, 1'b1, 1'b0, 1'b1, 32'd0);
        end
        cyc("tr_rst",  S_T, OP_R, 1'b1, 1'b1, 1'b1, 1'b1, 32'd0);
        cyc("tr_out",  S_F, OP_R, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
